// File: rtl/prbs_ctrl.sv
// Round-robin session controller that shares one PRBS byte generator between NUM_REQ requesters.
// Define PRBS_CTRL_CHK_EN to add the sticky chk_err pattern checker on the forwarded stream.
module prbs_ctrl #(
   parameter int NUM_REQ = 2,
   parameter int LEN_W   = 16
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*32-1:0]    req_pat,
   input  logic [NUM_REQ*8-1:0]     req_n,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic                     abort,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     prbs_rstn,
   output logic [31:0]              prbs_in,
   output logic [7:0]               prbs_n,
   input  logic [7:0]               prbs_out,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy
`ifdef PRBS_CTRL_CHK_EN
   ,
   output logic                     chk_err
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [2:0] {IDLE, LOAD, PRIME, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               prbsRstn_q, prbsRstn_d;
   logic [31:0]        prbsIn_q, prbsIn_d;
   logic [7:0]         prbsN_q, prbsN_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               outValid_q, outValid_d;
   logic [7:0]         outData_q, outData_d;
   logic [NUM_REQ-1:0] done_q, done_d;

   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   cand;
   logic               found;
   logic [31:0]        patSel;
   logic [7:0]         nSel;
   logic [LEN_W-1:0]   lenSel;

   // Search starts one past the last granted requester so a re-request never beats a waiting peer.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      patSel = '0;
      nSel   = '0;
      lenSel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == IDX_W'(i)) begin
            patSel = req_pat[32*i +: 32];
            nSel   = req_n[8*i +: 8];
            lenSel = req_len[LEN_W*i +: LEN_W];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      gnt_d      = gnt_q;
      prbsIn_d   = prbsIn_q;
      prbsN_d    = prbsN_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      outValid_d = 1'b0;
      outData_d  = outData_q;
      done_d     = '0;
      prbsRstn_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = LOAD;
               idx_d       = pick;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               prbsIn_d    = patSel;
               // The generator reads n=0 as 256 repeats, so a zero count becomes one.
               prbsN_d     = (nSel == 8'd0) ? 8'd1 : nSel;
               len_d       = lenSel;
               cnt_d       = '0;
            end
         end
         LOAD: begin
            state_d = (abort || len_q == '0) ? DONE : PRIME;
         end
         PRIME: begin
            state_d = abort ? DONE : RUN;
         end
         RUN: begin
            if (abort) begin
               state_d = DONE;
            end else begin
               outValid_d = 1'b1;
               outData_d  = prbs_out;
               cnt_d      = cnt_q + LEN_W'(1);
               if (cnt_d == len_q) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = idx_q;
         end
         default: state_d = IDLE;
      endcase

      if (state_d == DONE) begin
         done_d = gnt_q;
         gnt_d  = '0;
      end
      prbsRstn_d = (state_d == PRIME) || (state_d == RUN);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= IDLE;
         ptr_q      <= IDX_W'(NUM_REQ - 1);
         idx_q      <= '0;
         gnt_q      <= '0;
         prbsRstn_q <= 1'b0;
         prbsIn_q   <= '0;
         prbsN_q    <= 8'd1;
         len_q      <= '0;
         cnt_q      <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         gnt_q      <= gnt_d;
         prbsRstn_q <= prbsRstn_d;
         prbsIn_q   <= prbsIn_d;
         prbsN_q    <= prbsN_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         done_q     <= done_d;
      end
   end

`ifdef PRBS_CTRL_CHK_EN
   logic       chkErr_q, chkErr_d;
   logic [7:0] chkExp;
   logic       inPattern;

   // Only the first 4*n bytes are pattern bytes; the LFSR tail is not predictable here.
   always_comb begin
      chkExp    = 8'h00;
      inPattern = 32'(cnt_q) < {22'd0, prbsN_q, 2'b00};
      case (cnt_q[1:0])
         2'd0:    chkExp = prbsIn_q[31:24];
         2'd1:    chkExp = prbsIn_q[23:16];
         2'd2:    chkExp = prbsIn_q[15:8];
         default: chkExp = prbsIn_q[7:0];
      endcase
      chkErr_d = chkErr_q;
      if (state_q == IDLE && state_d == LOAD) begin
         chkErr_d = 1'b0;
      end else if (state_q == RUN && !abort && inPattern && prbs_out != chkExp) begin
         chkErr_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) chkErr_q <= 1'b0;
      else       chkErr_q <= chkErr_d;
   end

   assign chk_err = chkErr_q;
`endif

   assign gnt       = gnt_q;
   assign prbs_rstn = prbsRstn_q;
   assign prbs_in   = prbsIn_q;
   assign prbs_n    = prbsN_q;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_prbs_ctrl.sv
// Testbench for prbs_ctrl: behavioural PRBS generator plus a byte scoreboard on out_valid.
// Build with PRBS_CTRL_CHK_EN defined to also exercise chk_err.
module tb_prbs_ctrl;

   localparam int NUM_REQ = 2;
   localparam int LEN_W   = 16;

   logic                     CLK = 1'b0;
   logic                     RSTn;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*32-1:0]    req_pat;
   logic [NUM_REQ*8-1:0]     req_n;
   logic [NUM_REQ*LEN_W-1:0] req_len;
   logic                     abort;
   logic [NUM_REQ-1:0]       gnt;
   logic                     prbs_rstn;
   logic [31:0]              prbs_in;
   logic [7:0]               prbs_n;
   logic [7:0]               prbs_out;
   logic                     out_valid;
   logic [7:0]               out_data;
   logic [NUM_REQ-1:0]       done;
   logic                     busy;
`ifdef PRBS_CTRL_CHK_EN
   logic                     chk_err;
`endif

   int         vectors     = 0;
   int         miscompares = 0;
   int         validCount  = 0;
   logic [7:0] expQ[$];
   logic [7:0] corruptMask = 8'h00;

   logic [7:0] gOut  = 8'h00;
   logic [7:0] gLfsr = 8'h01;
   int         gIdx  = 0;
   int         gN;

   prbs_ctrl #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
      .CLK(CLK), .RSTn(RSTn), .req(req), .req_pat(req_pat), .req_n(req_n),
      .req_len(req_len), .abort(abort), .gnt(gnt), .prbs_rstn(prbs_rstn),
      .prbs_in(prbs_in), .prbs_n(prbs_n), .prbs_out(prbs_out),
      .out_valid(out_valid), .out_data(out_data), .done(done), .busy(busy)
`ifdef PRBS_CTRL_CHK_EN
      , .chk_err(chk_err)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] lfsrStep(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [7:0] lfsrSeed(input logic [31:0] p);
      return (p[7:0] == 8'h00) ? 8'h01 : p[7:0];
   endfunction

   // Expected k-th session byte: pattern MSB first for max(n,1) repeats, then LFSR bytes.
   function automatic logic [7:0] expByte(input logic [31:0] pat, input logic [7:0] n, input int k);
      int         reps;
      logic [7:0] s;
      reps = (n == 8'd0) ? 1 : int'(n);
      if (k < 4 * reps) return pat[31 - 8*(k % 4) -: 8];
      s = lfsrSeed(pat);
      for (int j = 0; j <= k - 4 * reps; j++) s = lfsrStep(s);
      return s;
   endfunction

   // Generator model: n=0 means 256 repeats here, as in the real block.
   assign gN = (prbs_n == 8'd0) ? 256 : int'(prbs_n);
   always @(posedge CLK) begin
      if (!prbs_rstn) begin
         gIdx  <= 0;
         gLfsr <= lfsrSeed(prbs_in);
         gOut  <= 8'h00;
      end else begin
         if (gIdx < 4 * gN) begin
            gOut <= prbs_in[31 - 8*(gIdx % 4) -: 8];
         end else begin
            gOut  <= lfsrStep(gLfsr);
            gLfsr <= lfsrStep(gLfsr);
         end
         gIdx <= gIdx + 1;
      end
   end
   assign prbs_out = gOut ^ corruptMask;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every forwarded byte pops the oldest expectation.
   always @(negedge CLK) begin
      if (RSTn === 1'b1 && out_valid === 1'b1) begin
         validCount++;
         checkOutput("sb_has_entry", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) checkOutput("sb_byte", 32'(out_data), 32'(expQ.pop_front()));
      end
   end

   task automatic applyStimulus(input int idx, input logic [31:0] pat, input logic [7:0] n,
                                input logic [LEN_W-1:0] len, input int pushCount);
      req_pat[32*idx +: 32]        = pat;
      req_n[8*idx +: 8]            = n;
      req_len[LEN_W*idx +: LEN_W]  = len;
      req[idx]                     = 1'b1;
      for (int k = 0; k < pushCount; k++) expQ.push_back(expByte(pat, n, k));
   endtask

   task automatic waitGrant(input int idx, input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (gnt !== '0) break;
      end
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'd1 << idx);
   endtask

   task automatic waitDone(input int idx, input string tag, input bit dropReq);
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (done !== '0) break;
      end
      checkOutput({tag, "_done"}, 32'(done), 32'd1 << idx);
      if (dropReq) req[idx] = 1'b0;
      @(negedge CLK);
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int                 base;
      int                 lat;
      int                 seen;
      logic [NUM_REQ-1:0] doneSeen;

      RSTn = 1'b0; req = '0; req_pat = '0; req_n = '0; req_len = '0; abort = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_prbs_rstn", 32'(prbs_rstn), 32'd0);
      checkOutput("rst_prbs_in", prbs_in, 32'd0);
      checkOutput("rst_prbs_n", 32'(prbs_n), 32'd1);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_data", 32'(out_data), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef PRBS_CTRL_CHK_EN
      checkOutput("rst_chk_err", 32'(chk_err), 32'd0);
`endif
      RSTn = 1'b1;
      @(negedge CLK);

      $display("[TB] single request, n=2 len=8");
      base = validCount;
      applyStimulus(0, 32'hA1B2C3D4, 8'd2, 16'd8, 8);
      waitGrant(0, "single");
      checkOutput("single_prbs_in", prbs_in, 32'hA1B2C3D4);
      checkOutput("single_prbs_n", 32'(prbs_n), 32'd2);
      checkOutput("single_load_rstn", 32'(prbs_rstn), 32'd0);
      checkOutput("single_busy", 32'(busy), 32'd1);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      checkOutput("single_latency", 32'(lat), 32'd3);
      waitDone(0, "single", 1'b1);
      checkOutput("single_count", 32'(validCount - base), 32'd8);
      checkOutput("single_idle_rstn", 32'(prbs_rstn), 32'd0);

      $display("[TB] LFSR tail, n=1 len=6");
      base = validCount;
      applyStimulus(1, 32'h0000ACE1, 8'd1, 16'd6, 6);
      waitGrant(1, "tail");
      waitDone(1, "tail", 1'b1);
      checkOutput("tail_count", 32'(validCount - base), 32'd6);
      checkOutput("tail_queue", 32'(expQ.size()), 32'd0);

      $display("[TB] arbitration with both requests held");
      base = validCount;
      applyStimulus(0, 32'h01020304, 8'd1, 16'd4, 4);
      applyStimulus(1, 32'h55667788, 8'd1, 16'd4, 4);
      for (int k = 0; k < 4; k++) expQ.push_back(expByte(32'h01020304, 8'd1, k));
      for (int k = 0; k < 4; k++) expQ.push_back(expByte(32'h55667788, 8'd1, k));
      waitGrant(0, "arb1");
      waitDone(0, "arb1", 1'b0);
      waitGrant(1, "arb2");
      waitDone(1, "arb2", 1'b0);
      waitGrant(0, "arb3");
      waitDone(0, "arb3", 1'b0);
      waitGrant(1, "arb4");
      req[0] = 1'b0;
      waitDone(1, "arb4", 1'b1);
      checkOutput("arb_count", 32'(validCount - base), 32'd16);

      $display("[TB] len=0 session");
      base = validCount;
      applyStimulus(0, 32'hCAFEF00D, 8'd1, 16'd0, 0);
      waitGrant(0, "len0");
      @(negedge CLK);
      checkOutput("len0_done", 32'(done), 32'd1);
      checkOutput("len0_gnt_clear", 32'(gnt), 32'd0);
      req[0] = 1'b0;
      @(negedge CLK);
      checkOutput("len0_count", 32'(validCount - base), 32'd0);

      $display("[TB] n=0 session");
      base = validCount;
      applyStimulus(1, 32'h11223344, 8'd0, 16'd7, 7);
      waitGrant(1, "n0");
      checkOutput("n0_prbs_n", 32'(prbs_n), 32'd1);
      waitDone(1, "n0", 1'b1);
      checkOutput("n0_count", 32'(validCount - base), 32'd7);

      $display("[TB] abort on the third byte");
      base = validCount;
      applyStimulus(0, 32'h9ABCDEF0, 8'd3, 16'd100, 3);
      applyStimulus(1, 32'h0BADBEEF, 8'd1, 16'd2, 2);
      waitGrant(0, "abort");
      seen = 0;
      for (int i = 0; i < 20 && seen < 3; i++) begin
         @(negedge CLK);
         if (out_valid === 1'b1) seen++;
      end
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd1);
      req[0] = 1'b0;
      waitGrant(1, "after_abort");
      waitDone(1, "after_abort", 1'b1);
      checkOutput("abort_count", 32'(validCount - base), 32'd5);

      $display("[TB] reset in the middle of a session");
      applyStimulus(0, 32'h13579BDF, 8'd1, 16'd50, 50);
      waitGrant(0, "rst_mid");
      repeat (6) @(negedge CLK);
      RSTn = 1'b0;
      #1;
      checkOutput("rst_mid_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_rstn", 32'(prbs_rstn), 32'd0);
      expQ.delete();
      req = '0;
      doneSeen = '0;
      repeat (2) @(negedge CLK) doneSeen |= done;
      RSTn = 1'b1;
      repeat (5) @(negedge CLK) doneSeen |= done;
      checkOutput("rst_mid_no_done", 32'(doneSeen), 32'd0);

`ifdef PRBS_CTRL_CHK_EN
      $display("[TB] pattern checker");
      corruptMask = 8'h01;
      applyStimulus(0, 32'hDEADBEEF, 8'd1, 16'd6, 0);
      for (int k = 0; k < 6; k++) expQ.push_back(expByte(32'hDEADBEEF, 8'd1, k) ^ 8'h01);
      waitGrant(0, "chk_bad");
      waitDone(0, "chk_bad", 1'b1);
      checkOutput("chk_err_set", 32'(chk_err), 32'd1);
      corruptMask = 8'h00;
      applyStimulus(1, 32'h0F1E2D3C, 8'd1, 16'd4, 4);
      waitGrant(1, "chk_good");
      checkOutput("chk_err_clear", 32'(chk_err), 32'd0);
      waitDone(1, "chk_good", 1'b1);
      checkOutput("chk_err_clean", 32'(chk_err), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
